// File: rtl/demux_1to4_deser_if.sv
// Serial-in / parallel-out bundle for the 1:4 deserialiser.
// The slave modport is the deserialiser; the master modport is the link plus consumer side.
interface demux_1to4_deser_if;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic [1:0] sel_out;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overrun;

  modport slave (
    input  din, din_valid, frame_start, dout_ready,
    output sel_out, dout, dout_valid, overrun
  );

  modport master (
    output din, din_valid, frame_start, dout_ready,
    input  sel_out, dout, dout_valid, overrun
  );
endinterface

// File: rtl/demux_1to4_deser.sv
// Rebuilds 4-bit words from a slot-ordered serial stream (slot k -> dout[k]).
// The word is visible one cycle after its slot-3 bit; a full, unaccepted output drops new words and sets overrun.
module demux_1to4_deser (
  input  logic                   clk,
  input  logic                   rst,
  demux_1to4_deser_if.slave      bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t     state, state_nxt;
  logic [1:0] sel, sel_nxt;
  logic [2:0] asm_q, asm_nxt;
  logic [3:0] dout_q, dout_nxt;
  logic       vld_q, vld_nxt;
  logic       ovr_q, ovr_nxt;
  logic       word_done;
  logic [3:0] word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 2'd0;
      asm_q  <= 3'd0;
      dout_q <= 4'd0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      asm_q  <= asm_nxt;
      dout_q <= dout_nxt;
      vld_q  <= vld_nxt;
      ovr_q  <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    asm_nxt   = asm_q;
    dout_nxt  = dout_q;
    vld_nxt   = vld_q;
    ovr_nxt   = ovr_q;
    word_done = 1'b0;
    word      = {bus.din, asm_q};

    // frame_start always wins, so a resync on the slot-3 cycle never completes the stale word
    if (bus.din_valid && bus.frame_start) begin
      asm_nxt[0] = bus.din;
      sel_nxt    = 2'd1;
      state_nxt  = COLLECT;
    end else if (bus.din_valid && state == COLLECT) begin
      case (sel)
        2'd0:    asm_nxt[0] = bus.din;
        2'd1:    asm_nxt[1] = bus.din;
        2'd2:    asm_nxt[2] = bus.din;
        default: word_done  = 1'b1;
      endcase
      sel_nxt = sel + 2'd1;
    end

    if (word_done && (!vld_q || bus.dout_ready)) begin
      dout_nxt = word;
      vld_nxt  = 1'b1;
    end else if (word_done) begin
      ovr_nxt = 1'b1;
    end else if (vld_q && bus.dout_ready) begin
      vld_nxt = 1'b0;
    end
  end

  assign bus.sel_out    = sel;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_demux_1to4_deser.sv
// Directed and random stimulus for demux_1to4_deser, checked each cycle against a queue-based word model.
module tb_demux_1to4_deser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  demux_1to4_deser_if bus ();

  demux_1to4_deser dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: bits of the word in progress (slot order), plus output register
  bit         m_in = 0;
  bit         mq[$];
  logic [3:0] m_dout = 4'd0;
  bit         m_vld = 0;
  bit         m_ovr = 0;
  logic [3:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit         done = 0;
    logic [3:0] w = 4'd0;
    if (bus.din_valid) begin
      if (bus.frame_start) begin
        mq.delete();
        mq.push_back(bus.din);
        m_in = 1;
      end else if (m_in) begin
        mq.push_back(bus.din);
        if (mq.size() == 4) begin
          for (int k = 0; k < 4; k++) w[k] = mq[k];
          mq.delete();
          done = 1;
        end
      end
    end
    if (done) begin
      if (!m_vld || bus.dout_ready) begin
        m_dout = w;
        m_vld  = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_vld && bus.dout_ready) begin
      m_vld = 0;
    end
  endtask

  task automatic check_all();
    chk("sel_out", {30'd0, bus.sel_out}, mq.size());
    chk("dout", {28'd0, bus.dout}, {28'd0, m_dout});
    chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, m_vld});
    chk("overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
  endtask

  // one clock: model sees the inputs of this cycle, DUT compared 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
  endtask

  task automatic idle(input int n);
    bus.din_valid = 0; bus.frame_start = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_word(input logic [3:0] w, input bit fs, input int gap);
    logic [3:0] ww;
    ww = w;
    for (int k = 0; k < 4; k++) begin
      bus.din = ww[k]; bus.din_valid = 1; bus.frame_start = fs && (k == 0);
      step();
      if (gap > 0) idle(gap);
    end
    bus.din_valid = 0; bus.frame_start = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_dout", {28'd0, bus.dout}, 32'd0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_sel", {30'd0, bus.sel_out}, 32'd0);
    chk("rst_ovr", {31'd0, bus.overrun}, 32'd0);
    m_in = 0; mq.delete(); m_dout = 4'd0; m_vld = 0; m_ovr = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [3:0] a;
    bus.din = 0; bus.din_valid = 0; bus.frame_start = 0; bus.dout_ready = 0;
    #12;
    do_reset();
    idle(5);

    // 1010 LSB-first, ready high
    bus.dout_ready = 1;
    send_word(4'b1010, 1, 0);
    chk("w1010_dout", {28'd0, bus.dout}, 32'hA);
    chk("w1010_vld", {31'd0, bus.dout_valid}, 32'd1);
    idle(2);

    // bits as a 4:1 mux emits them for s = 0..3, with 2-cycle gaps
    a = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      chk("mux_sel", {30'd0, bus.sel_out}, s);
      bus.din = a[s]; bus.din_valid = 1; bus.frame_start = (s == 0);
      step();
      idle(2);
    end
    chk("mux_dout", {28'd0, bus.dout}, 32'hA);
    idle(2);

    // back-to-back stream
    got.delete();
    send_word(4'hA, 1, 0);
    send_word(4'h5, 0, 0);
    send_word(4'hF, 0, 0);
    idle(2);
    chk("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_w0", {28'd0, got[0]}, 32'hA);
      chk("b2b_w1", {28'd0, got[1]}, 32'h5);
      chk("b2b_w2", {28'd0, got[2]}, 32'hF);
    end
    chk("b2b_ovr", {31'd0, bus.overrun}, 32'd0);

    // backpressure
    bus.dout_ready = 0;
    send_word(4'h3, 1, 0);
    send_word(4'hC, 0, 0);
    chk("bp_dout", {28'd0, bus.dout}, 32'h3);
    chk("bp_ovr", {31'd0, bus.overrun}, 32'd1);
    bus.dout_ready = 1;
    step();
    chk("bp_drop", {31'd0, bus.dout_valid}, 32'd0);

    // resync after a partial word
    do_reset();
    bus.din = 1; bus.din_valid = 1; step();
    bus.din = 1; step();
    send_word(4'h6, 0, 0);
    send_word(4'h6, 1, 0);
    chk("resync_dout", {28'd0, bus.dout}, 32'h6);
    chk("resync_ovr", {31'd0, bus.overrun}, 32'd0);

    // reset mid-frame, then frameless bits are ignored
    bus.din = 1; bus.din_valid = 1; bus.frame_start = 1; step();
    bus.frame_start = 0; step();
    bus.din_valid = 0;
    do_reset();
    send_word(4'hF, 0, 0);
    chk("post_rst_vld", {31'd0, bus.dout_valid}, 32'd0);
    chk("post_rst_sel", {30'd0, bus.sel_out}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.din         = 1'($urandom_range(0, 1));
      bus.din_valid   = ($urandom_range(0, 3) != 0);
      bus.frame_start = ($urandom_range(0, 9) == 0);
      bus.dout_ready  = ($urandom_range(0, 2) != 0);
      step();
      if (i == 300) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
